// File: rtl/run_ctrl.sv
// run_ctrl: program-run sequencer for the fetch stage.
// Drives the IF init/branch inputs, gates PC advance, stretches memory
// instructions into multi-cycle stalls, detects completion from the IF halt
// flag and keeps saturating cycle / retired-instruction counters.
module run_ctrl #(
  parameter int STALL_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             start,
  input  logic             halt,
  input  logic             br_req,
  input  logic             br_sign,
  input  logic [3:0]       br_off,
  input  logic             mem_req,
  output logic             if_init,
  output logic             if_branch_en,
  output logic             if_bSIGN,
  output logic [3:0]       if_bOFFSET,
  output logic             pc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The stall counter holds the number of extra wait cycles still to go
  // after the current one; it is loaded when a memory instruction is seen.
  localparam logic [3:0]       STALL_LOAD = 4'(STALL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t     state, state_next;
  logic [3:0] stall_cnt, stall_cnt_next;

  // State and stall counter register; init_n forces IDLE at any time.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state     <= S_IDLE;
      stall_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
    end
  end

  // Next-state logic plus the Mealy outputs pc_en and if_branch_en.
  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    pc_en          = 1'b0;
    if_branch_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_INIT;
      end
      S_INIT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        // halt beats a memory stall, which beats a branch
        if (halt) begin
          state_next = S_DONE;
        end else if (mem_req) begin
          state_next     = S_STALL;
          stall_cnt_next = STALL_LOAD;
        end else begin
          pc_en        = 1'b1;
          if_branch_en = br_req;
        end
      end
      S_STALL: begin
        // the memory instruction retires on the last stall cycle; no branch
        if (halt) begin
          state_next = S_DONE;
        end else if (stall_cnt != 4'd0) begin
          stall_cnt_next = stall_cnt - 4'd1;
        end else begin
          pc_en      = 1'b1;
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (start) state_next = S_INIT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs and the branch payload, zeroed when no branch is issued.
  assign if_init    = (state == S_IDLE) || (state == S_INIT);
  assign busy       = (state == S_RUN) || (state == S_STALL);
  assign done       = (state == S_DONE);
  assign if_bSIGN   = if_branch_en & br_sign;
  assign if_bOFFSET = if_branch_en ? br_off : 4'd0;

  // Saturating performance counters, cleared on every entry into INIT.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state_next == S_INIT) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy && (cycle_cnt != CNT_MAX)) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (pc_en && (instr_cnt != CNT_MAX)) instr_cnt <= instr_cnt + CNT_ONE;
    end
  end

endmodule
